// File: rtl/reg_cmd_pkg.sv
// Shared opcode/state encodings and widths for the register command sequencer.
package reg_cmd_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_INC_N = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_INC  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        cmd_op_e             op;
        logic [DATA_W-1:0]   data;
    } cmd_t;

endpackage

// File: rtl/reg_cmd_seq_if.sv
// Command handshake plus downstream register strobes of the sequencer.
interface reg_cmd_seq_if;
    import reg_cmd_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              ld;
    logic              inc;
    logic [DATA_W-1:0] in;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, ld, inc, in, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, ld, inc, in, done
    );

endinterface

// File: rtl/reg4.sv
// Downstream 4-bit register: load has priority over increment, wraps on overflow.
module reg4
    import reg_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ld,
    input  logic              i_inc,
    input  logic [DATA_W-1:0] i_in,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_in;
        end else if (i_inc) begin
            r_q <= r_q + DATA_W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_cmd_seq.sv
// Command sequencer: turns LOAD/CLEAR/INC_N/NOP commands into ld/inc strobes
// for a 4-bit register and signals completion with a one-cycle done pulse.
module reg_cmd_seq
    import reg_cmd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    reg_cmd_seq_if.slave bus
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_in;
    logic              r_ld;
    logic              r_inc;
    logic              r_done;
    logic              r_ready;
    cmd_op_e           w_op;

    assign w_op = cmd_op_e'(bus.cmd_op);

    // Strobe flops are set on the same edge as the state they belong to,
    // so each is exactly a decode of the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_in    <= '0;
            r_ld    <= 1'b0;
            r_inc   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_ld   <= 1'b0;
            r_inc  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_ready <= 1'b0;
                        case (w_op)
                            OP_LOAD, OP_CLEAR: begin
                                r_state <= ST_LOAD;
                                r_ld    <= 1'b1;
                                r_in    <= (w_op == OP_LOAD) ? bus.cmd_data : '0;
                            end
                            OP_INC_N: begin
                                if (bus.cmd_data != '0) begin
                                    r_state <= ST_INC;
                                    r_cnt   <= CNT_W'(bus.cmd_data);
                                    r_inc   <= 1'b1;
                                end else begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                // Exit at 1 so the counter never decrements through 0.
                ST_INC: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        r_inc <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.ld        = r_ld;
    assign bus.inc       = r_inc;
    assign bus.in        = r_in;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_reg_cmd_seq.sv
// Scoreboard bench: reg_cmd_seq driving reg4, expected strobes queued at acceptance.
module tb_reg_cmd_seq;
    import reg_cmd_pkg::*;

    localparam int unsigned BUDGET = 64;
    localparam logic [2:0]  K_LD   = 3'b100;
    localparam logic [2:0]  K_INC  = 3'b010;
    localparam logic [2:0]  K_DONE = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] val;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] w_q;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    ev_t        q[$];
    logic [3:0] m_reg = 4'h0;
    logic [3:0] m_in  = 4'h0;

    reg_cmd_seq_if bus();

    reg_cmd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    reg4 u_reg4 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (bus.ld),
        .i_inc (bus.inc),
        .i_in  (bus.in),
        .o_q   (w_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [2:0] kind, input logic [3:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // Reference behaviour of one accepted command, starting at acceptance cycle a.
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] d, input int a);
        case (cmd_op_e'(op))
            OP_LOAD: begin
                m_in  = d;
                m_reg = d;
                push_ev(K_LD, d, a);
                push_ev(K_DONE, m_reg, a + 1);
            end
            OP_CLEAR: begin
                m_in  = 4'h0;
                m_reg = 4'h0;
                push_ev(K_LD, 4'h0, a);
                push_ev(K_DONE, m_reg, a + 1);
            end
            OP_INC_N: begin
                for (int i = 0; i < int'(d); i++) push_ev(K_INC, 4'h0, a + i);
                m_reg = 4'(m_reg + d);
                push_ev(K_DONE, m_reg, a + int'(d));
            end
            default: push_ev(K_DONE, m_reg, a);
        endcase
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] d, input bit hold, output int acc);
        int n = 0;
        acc = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && n < int'(BUDGET)) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 32'(bus.cmd_ready), 32'h1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (!hold) bus.cmd_valid = 1'b0;
            push_cmd(op, d, acc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < int'(BUDGET)) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'h0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Per-cycle monitor: handshake, held load value, and strobe ordering/timing.
    always @(negedge clk) begin : mon
        logic [2:0] s;
        ev_t        e;
        s = {bus.ld, bus.inc, bus.done};
        chk("ready", 32'(bus.cmd_ready), 32'(q.size() == 0));
        chk("in_hold", 32'(bus.in), 32'(m_in));
        if (s != 3'b000) begin
            if (q.size() == 0) begin
                chk("spurious_strobe", 32'(s), 32'h0);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", 32'(s), 32'(e.kind));
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == K_LD)   chk("ld_value", 32'(bus.in), 32'(e.val));
                if (e.kind == K_DONE) chk("reg_at_done", 32'(w_q), 32'(e.val));
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            chk("missing_strobe", 32'(s), 32'(q[0].kind));
            void'(q.pop_front());
        end
    end

    initial begin
        int   a1;
        int   a2;
        int   t0;
        int   n;
        bit   hold;
        cmd_t c;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_ld",    32'(bus.ld),        32'h0);
        chk("rst_inc",   32'(bus.inc),       32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_in",    32'(bus.in),        32'h0);
        chk("rst_reg",   32'(w_q),           32'h0);
        #1 rst_n = 1'b1;

        send(OP_LOAD, 4'hA, 1'b0, a1);
        wait_idle();
        chk("load_a_reg", 32'(w_q), 32'hA);

        send(OP_LOAD, 4'hE, 1'b0, a1);
        wait_idle();
        send(OP_INC_N, 4'h3, 1'b0, a1);
        wait_idle();
        chk("inc3_wrap_reg", 32'(w_q), 32'h1);

        send(OP_INC_N, 4'h0, 1'b0, a1);
        wait_idle();
        chk("inc0_reg", 32'(w_q), 32'h1);
        send(OP_NOP, 4'h9, 1'b0, a1);
        wait_idle();
        chk("nop_reg", 32'(w_q), 32'h1);

        send(OP_CLEAR, 4'h7, 1'b0, a1);
        wait_idle();
        chk("clear_reg", 32'(w_q), 32'h0);

        send(OP_LOAD, 4'h3, 1'b1, a1);
        send(OP_INC_N, 4'h2, 1'b0, a2);
        chk("b2b_accept_cycle", 32'(a2), 32'(a1 + 3));
        wait_idle();
        chk("b2b_reg", 32'(w_q), 32'h5);

        for (int i = 0; i < 24; i++) begin
            c.op   = cmd_op_e'($urandom_range(0, 3));
            c.data = 4'($urandom_range(0, 15));
            hold   = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(c.op, c.data, hold, a1);
            if (!hold) wait_idle();
        end
        wait_idle();
        chk("rand_reg", 32'(w_q), 32'(m_reg));

        send(OP_LOAD, 4'h9, 1'b0, a1);
        wait_idle();
        send(OP_INC_N, 4'h5, 1'b0, a1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != a1 + 1 && n < int'(BUDGET));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_inc",   32'(bus.inc),       32'h0);
        chk("abort_ld",    32'(bus.ld),        32'h0);
        chk("abort_done",  32'(bus.done),      32'h0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'h1);
        chk("abort_reg",   32'(w_q),           32'h0);
        q.delete();
        m_reg = 4'h0;
        m_in  = 4'h0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        t0 = cyc;
        send(OP_LOAD, 4'h6, 1'b0, a1);
        chk("first_after_reset", 32'(a1), 32'(t0 + 1));
        wait_idle();
        chk("post_reset_reg", 32'(w_q), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
